// File: rtl/ssd_scan_ctl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctl
// Scans four hex digits onto a multiplexed 4-digit seven-segment display.
// A slow scan-rate level (clk_ctl) from an upstream divider is edge-detected
// in the clk domain. Each rising edge advances the scanned digit. The
// digit-enable and segment outputs are registered one clk after the scan
// index and the inputs.
//
// Parameters
//   SEG_ACTIVE_LOW  1: outputs are active-low. 0: every output bit inverted.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   clk_ctl   scan-rate level, synchronous to clk
//   digit0-3  hex digit values (digit0 is the rightmost digit)
//   dp_mask   bit i lights the decimal point of digit i
//   blank_lz  1 = blank leading zeros on digit3..digit1
//   ssd_ctl   one-hot digit enable
//   ssd_out   segments {a,b,c,d,e,f,g,dp}
//   scan_idx  index of the digit currently being scanned
// ---------------------------------------------------------------------------
module ssd_scan_ctl #(
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_ctl,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic [3:0] digit3,
   input  logic [3:0] dp_mask,
   input  logic       blank_lz,
   output logic [3:0] ssd_ctl,
   output logic [7:0] ssd_out,
   output logic [1:0] scan_idx
);

   // The decode is built active-low. The inverted build XORs with all-ones.
   localparam logic [3:0] CTL_POL = (SEG_ACTIVE_LOW != 0) ? 4'h0 : 4'hF;
   localparam logic [7:0] OUT_POL = (SEG_ACTIVE_LOW != 0) ? 8'h00 : 8'hFF;

   // Active-low {a,b,c,d,e,f,g} glyphs. b and d use lowercase shapes.
   function automatic logic [6:0] hex_to_seg_n(input logic [3:0] hex);
      logic [6:0] seg_n;
      case (hex)
         4'h0: seg_n = 7'b000_0001;
         4'h1: seg_n = 7'b100_1111;
         4'h2: seg_n = 7'b001_0010;
         4'h3: seg_n = 7'b000_0110;
         4'h4: seg_n = 7'b100_1100;
         4'h5: seg_n = 7'b010_0100;
         4'h6: seg_n = 7'b010_0000;
         4'h7: seg_n = 7'b000_1111;
         4'h8: seg_n = 7'b000_0000;
         4'h9: seg_n = 7'b000_0100;
         4'hA: seg_n = 7'b000_1000;
         4'hB: seg_n = 7'b110_0000;
         4'hC: seg_n = 7'b011_0001;
         4'hD: seg_n = 7'b100_0010;
         4'hE: seg_n = 7'b011_0000;
         default: seg_n = 7'b011_1000;
      endcase
      return seg_n;
   endfunction

   logic       clk_ctl_d;
   logic       tick;
   logic       blank3;
   logic       blank2;
   logic       blank1;
   logic [3:0] sel_digit;
   logic       sel_blank;
   logic       sel_dp;
   logic [3:0] ctl_n;
   logic [7:0] out_n;
   logic [3:0] ssd_ctl_p1;
   logic [7:0] ssd_out_p1;

   assign tick = clk_ctl & ~clk_ctl_d;

   // A digit is a leading zero only if every digit to its left is one too.
   // digit0 is always shown so that a value of zero still displays "0".
   assign blank3 = blank_lz && (digit3 == 4'h0);
   assign blank2 = blank3 && (digit2 == 4'h0);
   assign blank1 = blank2 && (digit1 == 4'h0);

   // ---- stage p0: edge detect and scan counter ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_ctl_d <= 1'b0;
         scan_idx  <= 2'd0;
      end else begin
         clk_ctl_d <= clk_ctl;
         if (tick) begin
            scan_idx <= scan_idx + 2'd1;
         end
      end
   end

   always_comb begin
      sel_digit = digit0;
      sel_blank = 1'b0;
      ctl_n     = 4'b1110;
      case (scan_idx)
         2'd0: begin
            sel_digit = digit0;
            sel_blank = 1'b0;
            ctl_n     = 4'b1110;
         end
         2'd1: begin
            sel_digit = digit1;
            sel_blank = blank1;
            ctl_n     = 4'b1101;
         end
         2'd2: begin
            sel_digit = digit2;
            sel_blank = blank2;
            ctl_n     = 4'b1011;
         end
         default: begin
            sel_digit = digit3;
            sel_blank = blank3;
            ctl_n     = 4'b0111;
         end
      endcase
      // The decimal point ignores blanking.
      sel_dp = dp_mask[scan_idx];
      out_n  = {(sel_blank ? 7'h7F : hex_to_seg_n(sel_digit)), ~sel_dp};
   end

   // ---- stage p1: registered display drive ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ssd_ctl_p1 <= 4'hF ^ CTL_POL;
         ssd_out_p1 <= 8'hFF ^ OUT_POL;
      end else begin
         ssd_ctl_p1 <= ctl_n ^ CTL_POL;
         ssd_out_p1 <= out_n ^ OUT_POL;
      end
   end

   assign ssd_ctl = ssd_ctl_p1;
   assign ssd_out = ssd_out_p1;

endmodule
